// File: rtl/game_pkg.sv
// Shared constants and encodings for the grid-game player and trophy logic.
package game_pkg;

  localparam int ROWS            = 18;
  localparam int COLS            = 26;
  localparam int START_R         = 0;
  localparam int START_C         = 0;
  // Off-grid parking spot; differs from the trophy park row so IDLE never collects.
  localparam int PARK            = 31;
  localparam int TROPHY_PARK_ROW = 23;
  localparam int STEP_MAX        = 999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WIN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

endpackage

// File: rtl/dir_arbiter.sv
// Fixed-priority direction encoder: up > down > left > right.
module dir_arbiter
  import game_pkg::*;
(
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output dir_t dir
);

  always_comb begin
    dir = DIR_NONE;
    if (up)         dir = DIR_UP;
    else if (down)  dir = DIR_DOWN;
    else if (left)  dir = DIR_LEFT;
    else if (right) dir = DIR_RIGHT;
  end

endmodule

// File: rtl/player_control.sv
// Player position FSM: moves on move_tick with edge saturation, counts effective
// steps, pulses on trophy collection and latches the win state.
module player_control
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       game_start,
  input  logic       move_tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [2:0] trophy_cnt,
  output logic [4:0] row,
  output logic [4:0] column,
  output logic [9:0] steps,
  output logic       collect_pulse,
  output logic       win,
  output logic [1:0] state
);

  state_t      state_reg, state_next;
  logic [4:0]  row_reg, row_next;
  logic [4:0]  col_reg, col_next;
  logic [9:0]  steps_reg, steps_next;
  logic [2:0]  trophy_q;
  logic        pulse_reg, pulse_next;
  logic        moved;
  dir_t        dir;

  dir_arbiter u_dir_arbiter (
    .up    (up),
    .down  (down),
    .left  (left),
    .right (right),
    .dir   (dir)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      row_reg   <= 5'(PARK);
      col_reg   <= 5'(PARK);
      steps_reg <= '0;
      trophy_q  <= 3'b111;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      steps_reg <= steps_next;
      trophy_q  <= trophy_cnt;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (game_start) state_next = PLAY;
      PLAY:    if (trophy_cnt == 3'b000) state_next = WIN;
      WIN:     state_next = WIN;
      default: state_next = IDLE;
    endcase
  end

  // Bounds are tested before stepping so the 5-bit position never wraps.
  always_comb begin
    row_next   = row_reg;
    col_next   = col_reg;
    steps_next = steps_reg;
    moved      = 1'b0;
    case (state_reg)
      IDLE: begin
        row_next   = 5'(PARK);
        col_next   = 5'(PARK);
        steps_next = '0;
        if (game_start) begin
          row_next = 5'(START_R);
          col_next = 5'(START_C);
        end
      end
      PLAY: begin
        if (move_tick) begin
          case (dir)
            DIR_UP:    if (row_reg != 5'd0)           begin row_next = row_reg - 5'd1; moved = 1'b1; end
            DIR_DOWN:  if (row_reg != 5'(ROWS - 1))   begin row_next = row_reg + 5'd1; moved = 1'b1; end
            DIR_LEFT:  if (col_reg != 5'd0)           begin col_next = col_reg - 5'd1; moved = 1'b1; end
            DIR_RIGHT: if (col_reg != 5'(COLS - 1))   begin col_next = col_reg + 5'd1; moved = 1'b1; end
            default: ;
          endcase
        end
        if (moved && steps_reg != 10'(STEP_MAX)) steps_next = steps_reg + 10'd1;
      end
      default: ;
    endcase
  end

  assign pulse_next = (state_reg == PLAY) && (|(trophy_q & ~trophy_cnt));

  always_comb begin
    row           = row_reg;
    column        = col_reg;
    steps         = steps_reg;
    collect_pulse = pulse_reg;
    win           = (state_reg == WIN);
    state         = state_reg;
  end

endmodule

// File: tb/tb_player_control.sv
// Scoreboard bench: the driver queues hand-computed post-edge expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_player_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_start, move_tick, up, down, left, right;
  logic [2:0] trophy_cnt;
  logic [4:0] row, column;
  logic [9:0] steps;
  logic       collect_pulse, win;
  logic [1:0] state;

  player_control dut (
    .clk           (clk),
    .rst           (rst),
    .game_start    (game_start),
    .move_tick     (move_tick),
    .up            (up),
    .down          (down),
    .left          (left),
    .right         (right),
    .trophy_cnt    (trophy_cnt),
    .row           (row),
    .column        (column),
    .steps         (steps),
    .collect_pulse (collect_pulse),
    .win           (win),
    .state         (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] row;
    logic [4:0] col;
    logic [9:0] steps;
    logic [1:0] st;
    logic       pulse;
  } exp_t;

  localparam logic [3:0] B_NO = 4'b0000;
  localparam logic [3:0] B_UP = 4'b1000;
  localparam logic [3:0] B_DN = 4'b0100;
  localparam logic [3:0] B_LT = 4'b0010;
  localparam logic [3:0] B_RT = 4'b0001;

  exp_t sb[$];
  exp_t m_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      chk("sb_cycle", cyc, m_e.cyc);
      chk("row", {27'd0, row}, {27'd0, m_e.row});
      chk("column", {27'd0, column}, {27'd0, m_e.col});
      chk("steps", {22'd0, steps}, {22'd0, m_e.steps});
      chk("state", {30'd0, state}, {30'd0, m_e.st});
      chk("win", {31'd0, win}, {31'd0, (m_e.st == 2'd2)});
      chk("collect_pulse", {31'd0, collect_pulse}, {31'd0, m_e.pulse});
      $display("cyc %0d: row=%0d col=%0d steps=%0d state=%0d win=%0d pulse=%0d", cyc, row, column, steps,
               state, win, collect_pulse);
    end
  end

  task automatic step(input logic [3:0] btn, input logic tick, input logic start, input logic [2:0] tro,
                      input int er, input int ec, input int es, input int est, input logic ep);
    exp_t e;
    {up, down, left, right} = btn;
    move_tick  = tick;
    game_start = start;
    trophy_cnt = tro;
    e.cyc   = cyc + 1;
    e.row   = 5'(er);
    e.col   = 5'(ec);
    e.steps = 10'(es);
    e.st    = 2'(est);
    e.pulse = ep;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_row"}, {27'd0, row}, 32'd31);
    chk({tag, "_column"}, {27'd0, column}, 32'd31);
    chk({tag, "_steps"}, {22'd0, steps}, 32'd0);
    chk({tag, "_state"}, {30'd0, state}, 32'd0);
    chk({tag, "_win"}, {31'd0, win}, 32'd0);
    chk({tag, "_pulse"}, {31'd0, collect_pulse}, 32'd0);
  endtask

  // Asserts rst between edges and checks the outputs before the next edge arrives.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    {up, down, left, right} = B_NO;
    move_tick  = 1'b0;
    game_start = 1'b0;
    trophy_cnt = 3'b111;
    #1;
    check_reset_values(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int bounce(input int k);
    int p;
    p = k % 34;
    return (p <= 17) ? p : 34 - p;
  endfunction

  initial begin
    rst = 1'b1;
    {up, down, left, right} = B_NO;
    move_tick  = 1'b0;
    game_start = 1'b0;
    trophy_cnt = 3'b111;
    #2;
    check_reset_values("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    step(B_NO, 1'b1, 1'b0, 3'b111, 31, 31, 0, 0, 1'b0);
    // start and tick together: load only, no move
    step(B_RT, 1'b1, 1'b1, 3'b111, 0, 0, 0, 1, 1'b0);
    for (int i = 0; i < 30; i++)
      step(B_RT, 1'b1, 1'b0, 3'b111, 0, (i + 1 > 25) ? 25 : i + 1, (i + 1 > 25) ? 25 : i + 1, 1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(B_UP, 1'b1, 1'b0, 3'b111, 0, 25, 25, 1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(B_DN, 1'b1, 1'b0, 3'b111, i + 1, 25, 26 + i, 1, 1'b0);
    for (int i = 0; i < 20; i++)
      step(B_LT, 1'b1, 1'b0, 3'b111, 5, 24 - i, 31 + i, 1, 1'b0);
    step(B_UP | B_LT | B_RT, 1'b1, 1'b0, 3'b111, 4, 5, 51, 1, 1'b0);
    for (int i = 0; i < 10; i++)
      step(B_UP | B_LT | B_RT, 1'b0, 1'b0, 3'b111, 4, 5, 51, 1, 1'b0);
    step(B_LT | B_RT, 1'b1, 1'b0, 3'b111, 4, 4, 52, 1, 1'b0);
    step(B_DN | B_LT, 1'b1, 1'b0, 3'b111, 5, 4, 53, 1, 1'b0);

    step(B_NO, 1'b0, 1'b0, 3'b101, 5, 4, 53, 1, 1'b1);
    step(B_NO, 1'b0, 1'b0, 3'b101, 5, 4, 53, 1, 1'b0);
    // last trophy falls with a tick in the same cycle: move honoured, then WIN
    step(B_RT, 1'b1, 1'b0, 3'b000, 5, 5, 54, 2, 1'b1);
    for (int i = 0; i < 3; i++)
      step(B_DN, 1'b1, 1'b0, 3'b000, 5, 5, 54, 2, 1'b0);
    step(B_NO, 1'b1, 1'b0, 3'b111, 5, 5, 54, 2, 1'b0);
    step(B_NO, 1'b1, 1'b0, 3'b010, 5, 5, 54, 2, 1'b0);
    step(B_NO, 1'b0, 1'b1, 3'b010, 5, 5, 54, 2, 1'b0);

    async_reset("win_rst");
    step(B_NO, 1'b0, 1'b1, 3'b111, 0, 0, 0, 1, 1'b0);
    for (int k = 0; k < 1100; k++)
      step((bounce(k + 1) > bounce(k)) ? B_DN : B_UP, 1'b1, 1'b0, 3'b111, bounce(k + 1), 0,
           (k + 1 > 999) ? 999 : k + 1, 1, 1'b0);
    step(B_NO, 1'b0, 1'b1, 3'b111, 12, 0, 999, 1, 1'b0);

    async_reset("play_rst");
    step(B_NO, 1'b0, 1'b0, 3'b111, 31, 31, 0, 0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_control.md
# player_control

Player-position controller for the grid game. It turns debounced direction buttons into the player's `row`/`column` coordinates, which the trophy-collection logic compares against the trophy positions. It also watches the returned `trophy_cnt` bitmask to emit per-trophy collect pulses and to detect the win condition. It sits between the input/debounce stage and the trophy and render logic, driven by the same system clock.

## Interface
- ROWS, 18, number of playable rows; legal row range is 0..ROWS-1.
- COLS, 26, number of playable columns; legal column range is 0..COLS-1.
- START_R, 0, row loaded when the game starts.
- START_C, 0, column loaded when the game starts.
- PARK, 31, off-grid coordinate held in IDLE. It must differ from the trophy park row (23) so that no trophy is collected before the game starts.
- STEP_MAX, 999, saturation value of the step counter.

- clk  in  1  system clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- game_start  in  1  level or pulse; starts play when sampled high in IDLE.
- move_tick  in  1  one-cycle enable from the top-level divider; moves are accepted only on this tick.
- up, down, left, right  in  1 each  debounced button levels.
- trophy_cnt  in  3  remaining-trophy mask; bit set means the trophy is still on the board.
- row  out  5  player row.
- column  out  5  player column.
- steps  out  10  count of effective moves.
- collect_pulse  out  1  one-cycle pulse when any trophy bit falls.
- win  out  1  high while in the WIN state.
- state  out  2  IDLE=0, PLAY=1, WIN=2.

## Operation
- FSM with three states.
  - IDLE → PLAY when `game_start`=1.
  - PLAY → WIN when `trophy_cnt`==3'b000.
  - WIN is terminal until `rst`.
  - `game_start` is ignored outside IDLE.
- IDLE:
  - `row`=`column`=PARK, `steps`=0.
  - `trophy_cnt` is ignored.
- IDLE → PLAY transition: load `row`=START_R, `column`=START_C, `steps`=0.
- PLAY moves:
  - On each cycle with `move_tick`=1, one direction is selected by fixed priority: up > down > left > right.
  - Only the highest-priority pressed button is honoured; the others are dropped for that tick.
  - up: row-1. down: row+1. left: column-1. right: column+1.
  - Holding a button repeats the move on every tick.
- Edges:
  - Moves saturate at 0 and at ROWS-1 / COLS-1; there is no wrap-around.
  - A blocked move leaves the position unchanged and does not increment `steps`.
- `steps`:
  - Increments by 1 only on a move that changed the position.
  - Saturates at STEP_MAX.
- Collect detection:
  - A registered copy `trophy_q` is updated every cycle.
  - `collect_pulse` = |(`trophy_q` & ~`trophy_cnt`), registered, and asserted only in PLAY.
  - Several bits falling together produce a single pulse.
- WIN:
  - `row`, `column` and `steps` are frozen.
  - Buttons and `move_tick` are ignored.
  - `win`=1.
- Arithmetic is 5-bit unsigned; bounds are checked before the increment or decrement, so no overflow can reach the output.

## Timing
- Reset values:
  - `row`=`column`=PARK (31), `steps`=0, `state`=IDLE.
  - `collect_pulse`=0, `win`=0.
  - `trophy_q`=3'b111.
- `rst` asserted mid-PLAY or mid-WIN forces the reset values immediately, independent of the clock.
- `game_start` sampled at edge N: `state`=PLAY and position=START after edge N.
- Move latency: a `move_tick` sampled at edge N updates `row`/`column` and `steps` after edge N.
- Collect latency:
  - The trophy logic clears its bit one edge after the position matches.
  - `collect_pulse` is high for exactly the one cycle after the edge at which the falling bit is first seen.
- Win latency:
  - `trophy_cnt`==0 sampled at edge N puts `state`=WIN and `win`=1 after edge N.
  - A `move_tick` in that same cycle is still honoured, because the state is PLAY at sampling time.
- `game_start` and `move_tick` high in the same IDLE cycle: only the start load occurs; no move is taken.

## Structure
- Shared package `game_pkg` holds:
  - ROWS, COLS, PARK and trophy park constants;
  - the state enum (IDLE/PLAY/WIN);
  - the direction encoding (NONE, UP, DOWN, LEFT, RIGHT).
- One sub-module, `dir_arbiter`:
  - combinational priority encoder from {up, down, left, right} to the direction code;
  - instantiated once.
- Everything else is a single FSM/datapath in `player_control`.

## Test plan
- Assert `rst` → `row`=31, `column`=31, `steps`=0, `state`=0, `win`=0, `collect_pulse`=0.
- Pulse `game_start`, then hold right for 30 ticks from (0,0) → `column` stops at 25, `steps`=25; then 3 ticks of up → `row`=0, `steps` stays 25.
- At (5,5), assert up+left+right on one tick → (4,5), `steps`+1; buttons held with `move_tick`=0 for 10 cycles → no change.
- Drive `trophy_cnt` 111→101 → one-cycle `collect_pulse`; then 101→000 → single pulse, `state`=WIN and `win`=1 next cycle, further ticks leave the position frozen.
- Hold down for 1100 ticks while toggling between rows 0 and 17 with up/down → `steps` saturates at 999.
- Assert `rst` asynchronously mid-PLAY between clock edges → outputs return to reset values before the next edge; `game_start` pulsed while in PLAY → no reload.
